// File: rtl/spypath_chain_tester_if.sv
// spypath_chain_tester_if: control/status bundle for spypath_chain_tester; SPYPATH_FIRST_FAIL_EN adds first_fail/any_fail.
interface spypath_chain_tester_if #(
  parameter int TAP_W = 6,
  parameter int CNT_W = 16
);
  logic start;
  logic busy;
  logic done;
  logic [TAP_W-1:0] tap_sel;
  logic [CNT_W-1:0] num_trials;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] trial_count;
`ifdef SPYPATH_FIRST_FAIL_EN
  logic any_fail;
  logic [CNT_W-1:0] first_fail;
  modport master (
    output start, tap_sel, num_trials,
    input  busy, done, err_count, trial_count, any_fail, first_fail
  );
  modport slave (
    input  start, tap_sel, num_trials,
    output busy, done, err_count, trial_count, any_fail, first_fail
  );
`else
  modport master (
    output start, tap_sel, num_trials,
    input  busy, done, err_count, trial_count
  );
  modport slave (
    input  start, tap_sel, num_trials,
    output busy, done, err_count, trial_count
  );
`endif
endinterface

// File: rtl/spypath_chain_tester.sv
// spypath_chain_tester: launches transitions down a spypath_3_1 chain and counts late-arriving tap samples.
// Optional SPYPATH_FIRST_FAIL_EN reports the first failing trial (first_fail/any_fail).
module spypath_3_1 (
  input  logic a,
  input  logic s0,
  input  logic s1,
  input  logic s2,
  input  logic s3,
  output logic y
);
  assign y = ((a | s0 | s1) & s2) | s3;
endmodule

module spypath_chain_tester #(
  parameter int N_STAGES      = 10,
  parameter int TAP_W         = 6,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input logic clk,
  input logic rst,
  spypath_chain_tester_if.slave bus
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, CAPTURE, SETTLE, COMPARE, FINISH} stateT;
  stateT state, stateNext;
  logic launchQ, captureQ, tapVal, busyQ, doneQ;
  logic accept, mismatch, lastTrial;
  logic [TAP_W-1:0] tapQ;
  logic [CNT_W-1:0] numQ, errCnt, trialCnt;
  logic [SW-1:0] settleCnt;
  logic [N_STAGES-1:0] chainOut;
  for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
    (* keep *) logic stageIn;
    (* keep *) logic stageOut;
    if (k == 0) begin : g_head
      assign stageIn = launchQ;
    end else begin : g_link
      assign stageIn = g_stage[k-1].stageOut;
    end
    spypath_3_1 u_cell (.a(stageIn), .s0(1'b0), .s1(1'b0), .s2(1'b1), .s3(1'b0), .y(stageOut));
    assign chainOut[k] = stageOut;
  end
  // Out-of-range taps fall through to the last stage.
  always_comb begin
    tapVal = chainOut[N_STAGES-1];
    for (int i = 0; i < N_STAGES - 1; i++) tapVal = (tapQ == TAP_W'(i)) ? chainOut[i] : tapVal;
  end
  assign accept    = state == IDLE && bus.start;
  assign mismatch  = tapVal != captureQ;
  assign lastTrial = trialCnt + 1'b1 == numQ;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= stateNext;
  end
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = bus.start ? (bus.num_trials == '0 ? FINISH : LAUNCH) : IDLE;
      LAUNCH:  stateNext = CAPTURE;
      CAPTURE: stateNext = SETTLE;
      SETTLE:  stateNext = settleCnt == '0 ? COMPARE : SETTLE;
      COMPARE: stateNext = lastTrial ? FINISH : LAUNCH;
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      launchQ   <= 1'b0;
      captureQ  <= 1'b0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
      tapQ      <= '0;
      numQ      <= '0;
      errCnt    <= '0;
      trialCnt  <= '0;
      settleCnt <= '0;
    end else begin
      doneQ <= state == FINISH;
      if (accept) begin
        tapQ     <= bus.tap_sel;
        numQ     <= bus.num_trials;
        errCnt   <= '0;
        trialCnt <= '0;
        busyQ    <= 1'b1;
      end
      if (state == FINISH) busyQ <= 1'b0;
      if (state == LAUNCH) launchQ <= ~launchQ;
      // Timing-critical sample, one clock after the launch edge.
      if (state == CAPTURE) begin
        captureQ  <= tapVal;
        settleCnt <= SW'(SETTLE_CYCLES - 1);
      end
      if (state == SETTLE && settleCnt != '0) settleCnt <= settleCnt - 1'b1;
      if (state == COMPARE) begin
        trialCnt <= trialCnt + 1'b1;
        if (mismatch && errCnt != '1) errCnt <= errCnt + 1'b1;
      end
    end
  end
  assign bus.busy        = busyQ;
  assign bus.done        = doneQ;
  assign bus.err_count   = errCnt;
  assign bus.trial_count = trialCnt;
`ifdef SPYPATH_FIRST_FAIL_EN
  logic anyFailQ;
  logic [CNT_W-1:0] firstFailQ;
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      anyFailQ   <= 1'b0;
      firstFailQ <= '1;
    end else if (state == COMPARE && mismatch && !anyFailQ) begin
      anyFailQ   <= 1'b1;
      firstFailQ <= trialCnt;
    end
  end
  assign bus.any_fail   = anyFailQ;
  assign bus.first_fail = firstFailQ;
`endif
endmodule

// File: tb/tb_spypath_chain_tester.sv
// tb_spypath_chain_tester: randomized runs against a trial-level model; extra stage-5 delay is emulated by forcing a stale value.
module tb_spypath_chain_tester;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  bit injA = 1'b0, injB = 1'b0, forcedA = 1'b0, forcedB = 1'b0;
  logic [1:0] histA = '0, histB = '0;
  always #5 clk = ~clk;
  spypath_chain_tester_if #(.TAP_W(6), .CNT_W(16)) ifa ();
  spypath_chain_tester_if #(.TAP_W(6), .CNT_W(4)) ifb ();
  spypath_chain_tester #(.N_STAGES(10), .TAP_W(6), .CNT_W(16), .SETTLE_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(ifa));
  spypath_chain_tester #(.N_STAGES(10), .TAP_W(6), .CNT_W(4), .SETTLE_CYCLES(2)) d4 (.clk(clk), .rst(rst), .bus(ifb));
  // Stage 5 sees its input about 1.5 clocks late: stale at capture, settled long before golden.
  always @(negedge clk) begin
    histA = {histA[0], dut.g_stage[4].stageOut};
    histB = {histB[0], d4.g_stage[4].stageOut};
    if (injA) begin
      force dut.g_stage[5].stageOut = histA[1];
      forcedA = 1'b1;
    end else if (forcedA) begin
      release dut.g_stage[5].stageOut;
      forcedA = 1'b0;
    end
    if (injB) begin
      force d4.g_stage[5].stageOut = histB[1];
      forcedB = 1'b1;
    end else if (forcedB) begin
      release d4.g_stage[5].stageOut;
      forcedB = 1'b0;
    end
  end
  task automatic runA(input int tap, input int n, input bit inj, input int poke, input string tag);
    int cyc, lim, expCyc, expErr;
    expCyc = 1 + n * (3 + 8);
    expErr = (inj && tap >= 5) ? n : 0;
    lim = expCyc + 20;
    @(negedge clk);
    injA = inj;
    ifa.tap_sel = 6'(tap);
    ifa.num_trials = 16'(n);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifa.tap_sel = 6'(tap ^ 63);
    ifa.num_trials = 16'(n + 7);
    checks++;
    if (ifa.busy !== 1'b1 || ifa.trial_count !== 16'd0 || ifa.err_count !== 16'd0) begin
      errors++;
      $display("FAIL %s start_state busy=%b trial=%0d err=%0d want busy=1 trial=0 err=0", tag, ifa.busy, ifa.trial_count, ifa.err_count);
    end
    cyc = 0;
    while (ifa.done !== 1'b1 && cyc < lim) begin
      ifa.start = (cyc == poke);
      @(negedge clk);
      cyc++;
    end
    ifa.start = 1'b0;
    checks++;
    if (cyc !== expCyc) begin errors++; $display("FAIL %s run_cycles got %0d want %0d", tag, cyc, expCyc); end
    checks++;
    if (ifa.err_count !== 16'(expErr)) begin errors++; $display("FAIL %s err_count got %0d want %0d", tag, ifa.err_count, expErr); end
    checks++;
    if (ifa.trial_count !== 16'(n)) begin errors++; $display("FAIL %s trial_count got %0d want %0d", tag, ifa.trial_count, n); end
    checks++;
    if (ifa.busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", tag, ifa.busy); end
`ifdef SPYPATH_FIRST_FAIL_EN
    checks++;
    if (ifa.any_fail !== (expErr != 0) || ifa.first_fail !== (expErr != 0 ? 16'd0 : 16'hffff)) begin
      errors++;
      $display("FAIL %s first_fail got %b/%0d want %b/%0d", tag, ifa.any_fail, ifa.first_fail, expErr != 0, expErr != 0 ? 0 : 65535);
    end
`endif
    @(negedge clk);
    checks++;
    if (ifa.done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", tag, ifa.done); end
    injA = 1'b0;
  endtask
  task automatic runB(input int tap, input int n, input bit inj, input string tag);
    int cyc, lim, expCyc, expErr;
    expCyc = 1 + n * (3 + 2);
    expErr = (inj && tap >= 5) ? n : 0;
    lim = expCyc + 20;
    @(negedge clk);
    injB = inj;
    ifb.tap_sel = 6'(tap);
    ifb.num_trials = 4'(n);
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    checks++;
    if (ifb.err_count !== 4'd0 || ifb.trial_count !== 4'd0) begin
      errors++;
      $display("FAIL %s cleared_on_start err=%0d trial=%0d want 0/0", tag, ifb.err_count, ifb.trial_count);
    end
    cyc = 0;
    while (ifb.done !== 1'b1 && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== expCyc) begin errors++; $display("FAIL %s run_cycles got %0d want %0d", tag, cyc, expCyc); end
    checks++;
    if (ifb.err_count !== 4'(expErr)) begin errors++; $display("FAIL %s err_count got %0d want %0d", tag, ifb.err_count, expErr); end
    checks++;
    if (ifb.trial_count !== 4'(n)) begin errors++; $display("FAIL %s trial_count got %0d want %0d", tag, ifb.trial_count, n); end
    injB = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin errors++; $display("FAIL reset_a_flags busy=%b done=%b want 0/0", ifa.busy, ifa.done); end
    checks++;
    if (ifa.err_count !== 16'd0 || ifa.trial_count !== 16'd0) begin errors++; $display("FAIL reset_a_counts err=%0d trial=%0d want 0/0", ifa.err_count, ifa.trial_count); end
    checks++;
    if (ifb.busy !== 1'b0 || ifb.done !== 1'b0) begin errors++; $display("FAIL reset_b_flags busy=%b done=%b want 0/0", ifb.busy, ifb.done); end
    checks++;
    if (ifb.err_count !== 4'd0 || ifb.trial_count !== 4'd0) begin errors++; $display("FAIL reset_b_counts err=%0d trial=%0d want 0/0", ifb.err_count, ifb.trial_count); end
    rst = 1'b0;
  endtask
  task automatic test_slow_run;
    runA(9, 100, 1'b0, -1, "slow_run");
  endtask
  task automatic test_zero_trials;
    runA(5, 0, 1'b0, -1, "zero_trials");
  endtask
  task automatic test_forced_failure;
    runA(9, 20, 1'b1, -1, "forced_tap9");
    runA(4, 20, 1'b1, -1, "forced_tap4");
    runA(63, 6, 1'b1, -1, "forced_tap_oob");
  endtask
  task automatic test_start_while_busy;
    runA(9, 5, 1'b0, 10, "start_while_busy");
  endtask
  task automatic test_saturation;
    runB(9, 15, 1'b1, "sat_run1");
    runB(9, 15, 1'b1, "sat_run2");
    runB(2, 3, 1'b1, "sat_tap2");
  endtask
  task automatic test_reset_mid_run;
    bit sawDone;
    @(negedge clk);
    injA = 1'b1;
    ifa.tap_sel = 6'd9;
    ifa.num_trials = 16'd50;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    injA = 1'b0;
    checks++;
    if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin errors++; $display("FAIL mid_reset_flags busy=%b done=%b want 0/0", ifa.busy, ifa.done); end
    checks++;
    if (ifa.err_count !== 16'd0 || ifa.trial_count !== 16'd0) begin errors++; $display("FAIL mid_reset_counts err=%0d trial=%0d want 0/0", ifa.err_count, ifa.trial_count); end
    sawDone = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ifa.done === 1'b1 || ifa.busy === 1'b1) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin errors++; $display("FAIL mid_reset_no_done got activity=1 want 0"); end
    runA(9, 3, 1'b1, -1, "after_mid_reset");
  endtask
  task automatic test_random;
    for (int r = 0; r < 6; r++) runA(int'($urandom_range(0, 63)), int'($urandom_range(1, 10)), 1'($urandom_range(0, 1)), -1, "random");
  endtask
`ifdef SPYPATH_FIRST_FAIL_EN
  task automatic test_first_fail;
    int cyc;
    @(negedge clk);
    ifa.tap_sel = 6'd9;
    ifa.num_trials = 16'd12;
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    cyc = 0;
    while (ifa.trial_count !== 16'd7 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    injA = 1'b1;
    while (ifa.done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    injA = 1'b0;
    checks++;
    if (ifa.done !== 1'b1) begin errors++; $display("FAIL first_fail_timeout got done=%b want 1", ifa.done); end
    checks++;
    if (ifa.first_fail !== 16'd7 || ifa.any_fail !== 1'b1) begin errors++; $display("FAIL first_fail_value got %0d/%b want 7/1", ifa.first_fail, ifa.any_fail); end
    checks++;
    if (ifa.err_count !== 16'd5) begin errors++; $display("FAIL first_fail_errs got %0d want 5", ifa.err_count); end
  endtask
`endif
  initial begin
    ifa.start = 1'b0;
    ifa.tap_sel = '0;
    ifa.num_trials = '0;
    ifb.start = 1'b0;
    ifb.tap_sel = '0;
    ifb.num_trials = '0;
    test_reset();
    test_slow_run();
    test_zero_trials();
    test_forced_failure();
    test_start_while_busy();
    test_saturation();
    test_reset_mid_run();
    test_random();
`ifdef SPYPATH_FIRST_FAIL_EN
    test_first_fail();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spypath_chain_tester.md
Name: spypath_chain_tester

Overview:
- Parametrised delay-path tester.
- Builds an N_STAGES chain of spypath_3_1 cells with a tap multiplexer.
- Repeatedly launches a transition into the chain, captures the selected tap one clock later, and compares it against a late "golden" sample.
- Counts timing failures so that clock-sweep software can derive the path delay and flag Trojan-induced extra delay.

Parameters:
- N_STAGES, 10, number of spypath_3_1 stages in the chain (1..64).
- TAP_W, 6, width of tap_sel; must satisfy 2^TAP_W >= N_STAGES.
- CNT_W, 16, width of the trial and error counters.
- SETTLE_CYCLES, 8, clocks waited after capture before the golden sample (>=2).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a measurement run.
- tap_sel  in  TAP_W  selects the chain stage output under test; 0 = stage 0 output. Latched on start.
- num_trials  in  CNT_W  number of launch/capture trials in the run. Latched on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the run completes.
- err_count  out  CNT_W  number of trials where capture != golden.
- trial_count  out  CNT_W  number of trials completed so far.

Behaviour:
- Chain structure:
  - Stage k is spypath_3_1 with side inputs tied 1'b0, 1'b0, 1'b1, 1'b0.
  - Stage 0 input is the launch flop; stage k input is stage k-1 output.
  - All inter-stage nets carry a keep attribute.
- Tap selection: combinational mux on latched tap. A tap value >= N_STAGES selects the last stage.
- Reset values: busy=0, done=0, err_count=0, trial_count=0, launch flop=0, FSM=IDLE.
- FSM states: IDLE, LAUNCH, CAPTURE, SETTLE, COMPARE, FINISH.
- IDLE:
  - On start, latch tap_sel and num_trials, clear both counters, set busy.
  - If num_trials==0, go to FINISH; otherwise go to LAUNCH.
  - start is ignored in every state other than IDLE.
- LAUNCH: toggle the launch flop, so successive trials alternate rising and falling transitions. Go to CAPTURE.
- CAPTURE:
  - The capture register samples the selected tap at this edge, exactly one clock after the launch edge; this is the timing-critical sample.
  - Load the settle counter with SETTLE_CYCLES-1. Go to SETTLE.
- SETTLE: decrement the settle counter each cycle; at 0, go to COMPARE.
- COMPARE:
  - Sample the tap into the golden register.
  - If golden != capture, increment err_count, saturating at 2^CNT_W-1.
  - Increment trial_count.
  - If the new trial_count == latched num_trials, go to FINISH; otherwise go to LAUNCH.
- FINISH: pulse done for one cycle, clear busy, return to IDLE. Counters hold their values until the next accepted start.
- Latency per trial: 3 + SETTLE_CYCLES clocks.
- Latency of a run: 1 + num_trials*(3+SETTLE_CYCLES) clocks from start to done.
- Reset mid-run: the FSM returns to IDLE immediately, counters clear, and done is not pulsed.
- Capture and golden registers are internal only. Metastability on capture is acceptable by design, because failures are counted statistically.

Optional Feature:
- Macro: SPYPATH_FIRST_FAIL_EN.
- With the macro defined:
  - Adds output first_fail [CNT_W-1:0], holding the trial_count value at the first mismatching trial of the run.
  - Adds output any_fail [1], set on the first mismatch.
  - Both clear on reset and on an accepted start.
  - If no mismatch occurs, first_fail reads all-ones.
- Without the macro: neither port exists and no extra logic is inferred.

Test Plan:
- Slow-clock run: rst 2 cycles, tap_sel=9, num_trials=100, start. Required: busy high; done after 1+100*11=1101 cycles; trial_count=100; err_count=0.
- Zero trials: num_trials=0, start. Required: done pulses within 2 cycles; err_count=0; trial_count=0.
- Forced failure: sim model adds a delay greater than the clock period on stage 5, tap_sel=9, num_trials=20. Required: err_count=20. With tap_sel=4: err_count=0.
- Saturation: CNT_W=4, forced failure, num_trials=15. Required: err_count=15 and trial_count=15. With CNT_W=4 and num_trials=15 repeated twice, counters clear between runs.
- Reset mid-run: assert rst in cycle 40 of a 50-trial run. Required: busy=0 next cycle; counters 0; no done pulse. A start afterwards runs normally.
- start pulsed while busy: required to be ignored, with the run length unchanged. With SPYPATH_FIRST_FAIL_EN, a failure injected from trial 7 gives first_fail=7 and any_fail=1.
